// File: rtl/t01_fetch_pkg.sv
// Shared types and constants for the instruction/data fetch responders.
`timescale 1ns/1ps
package t01_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } fetch_state_t;

  localparam logic [3:0] BYTE_SEL_WORD = 4'hF;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/t01_fetch_timeout.sv
// Saturating bus-wait counter; reached flags the enabled cycle that brings the count to max_count.
`timescale 1ns/1ps
module t01_fetch_timeout #(
  parameter int unsigned MaxCount = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam int unsigned W = (MaxCount < 2) ? 1 : $clog2(MaxCount + 1);
  localparam logic [W-1:0] Limit = W'(MaxCount);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (MaxCount != 0) && (count != Limit)) begin
      count <= count + W'(1);
    end
  end

  // A max_count of zero disables the timeout entirely.
  assign reached = en && (MaxCount != 0) && (count >= Limit - W'(1));

endmodule

// File: rtl/t01_instruction_fetch_responder.sv
// Memory-side responder for core instruction fetch: bus read with a one-entry last-fetch buffer.
`timescale 1ns/1ps
module t01_instruction_fetch_responder
  import t01_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] address_IM,
  input  logic        hold,
  input  logic        invalidate,
  output logic [31:0] FetchedInstr,
  output logic        ihit,
  output logic        ifault,
  output logic        bus_read,
  output logic [31:0] bus_adr,
  output logic [3:0]  bus_sel,
  input  logic        bus_busy,
  input  logic        bus_ack,
  input  logic [31:0] bus_dat_i
);

  fetch_state_t state;
  logic [31:0]  req_addr;
  logic [31:0]  buf_tag;
  logic [31:0]  buf_data;
  logic [31:0]  fault_addr;
  logic         buf_valid;
  logic         delivered;
  logic         inval_seen;
  logic         fault_done;
  logic         timeout_reached;
  logic         tag_match;

  assign tag_match = (address_IM == buf_tag);

  t01_fetch_timeout #(
    .MaxCount(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (RST),
    .clr    (state != WAIT),
    .en     (state == WAIT),
    .reached(timeout_reached)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      FetchedInstr <= '0;
      ihit         <= 1'b0;
      ifault       <= 1'b0;
      bus_read     <= 1'b0;
      bus_adr      <= '0;
      bus_sel      <= '0;
      req_addr     <= '0;
      buf_tag      <= RESET_VECTOR;
      buf_data     <= '0;
      buf_valid    <= 1'b0;
      delivered    <= 1'b0;
      inval_seen   <= 1'b0;
      fault_done   <= 1'b0;
      fault_addr   <= '0;
    end else begin
      ihit   <= 1'b0;
      ifault <= 1'b0;
      if (!tag_match) delivered <= 1'b0;
      if (address_IM != fault_addr) fault_done <= 1'b0;
      if (invalidate && (state == ISSUE || state == WAIT)) inval_seen <= 1'b1;

      unique case (state)
        IDLE: begin
          if (!hold) begin
            if (address_IM[1:0] != 2'b00) begin
              if (!(fault_done && fault_addr == address_IM)) ifault <= 1'b1;
              fault_done <= 1'b1;
              fault_addr <= address_IM;
            end else if (tag_match && !invalidate && (delivered || buf_valid)) begin
              // Already-delivered match is a deliberate no-op: one ihit per fetch.
              if (!delivered) begin
                ihit         <= 1'b1;
                FetchedInstr <= buf_data;
                delivered    <= 1'b1;
              end
            end else begin
              req_addr   <= address_IM;
              bus_read   <= 1'b1;
              bus_adr    <= {address_IM[31:2], 2'b00};
              bus_sel    <= BYTE_SEL_WORD;
              inval_seen <= 1'b0;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!bus_busy) begin
            bus_read <= 1'b0;
            bus_sel  <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus_ack) begin
            buf_data  <= bus_dat_i;
            buf_tag   <= req_addr;
            buf_valid <= !(inval_seen || invalidate);
            delivered <= 1'b0;
            if (hold) begin
              state <= RESP;
            end else begin
              state <= IDLE;
              if (address_IM == req_addr) begin
                ihit         <= 1'b1;
                FetchedInstr <= bus_dat_i;
                delivered    <= 1'b1;
              end
            end
          end else if (timeout_reached) begin
            ifault <= 1'b1;
            state  <= IDLE;
          end
        end
        RESP: begin
          if (!hold) begin
            if (tag_match) begin
              ihit         <= 1'b1;
              FetchedInstr <= buf_data;
              delivered    <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Invalidate overrides any buffer update made above, including an in-flight fill.
      if (invalidate) begin
        buf_valid <= 1'b0;
        delivered <= 1'b0;
      end
    end
  end

endmodule
